// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM round-robin arbiter.
// Optional grant statistics are enabled with SDRAM_ARB_STATS_EN.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_pend_fifo.sv
// Owner-ID FIFO recording which master issued each outstanding read.
// The full flag comes only from the registered count, so a pop cannot make room for a push in the same cycle.
module sdram_arb_pend_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  owner_t push_id_i,
    input  logic   pop_i,
    output owner_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = $clog2(DEPTH);

    owner_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM slave between two masters, steering read returns by issue order.
// Define SDRAM_ARB_STATS_EN to add per-master grant counters with stats_clr.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4
`ifdef SDRAM_ARB_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              clk_clk,
    input  logic              reset_reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [1:0]        m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [1:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [1:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

`ifdef SDRAM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
`endif
    output logic              err_orphan
);

    arb_state_t state_q, state_d;
    owner_t     last_q, last_d;
    owner_t     own;
    logic       err_q;
    logic       req0, req1, req_own, req_oth;
    logic       granted, sel_read, sel_write, blk, accept;
    logic       fifo_full, fifo_empty;
    owner_t     fifo_head;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign granted = (state_q != IDLE);
    assign own     = (state_q == OWN1) ? OWNER_M1 : OWNER_M0;
    assign req_own = (own == OWNER_M1) ? req1 : req0;
    assign req_oth = (own == OWNER_M1) ? req0 : req1;

    // Slave side follows the owner combinationally; only the command strobes are gated.
    assign sel_read     = (own == OWNER_M1) ? m1_read : m0_read;
    assign sel_write    = (own == OWNER_M1) ? m1_write : m0_write;
    assign s_address    = (own == OWNER_M1) ? m1_address : m0_address;
    assign s_writedata  = (own == OWNER_M1) ? m1_writedata : m0_writedata;
    assign s_byteenable = (own == OWNER_M1) ? m1_byteenable : m0_byteenable;

    assign blk     = granted & sel_read & fifo_full;
    assign s_read  = granted & sel_read & ~blk;
    assign s_write = granted & sel_write;
    assign accept  = (s_read | s_write) & ~s_waitrequest;

    assign m0_waitrequest = (state_q == OWN0) ? (s_waitrequest | blk) : 1'b1;
    assign m1_waitrequest = (state_q == OWN1) ? (s_waitrequest | blk) : 1'b1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (last_q == OWNER_M0) ? OWN1 : OWN0;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (accept) begin
                    last_d = own;
                    if (req_oth) state_d = (own == OWNER_M1) ? OWN0 : OWN1;
                end else if (!req_own) begin
                    state_d = req_oth ? ((own == OWNER_M1) ? OWN0 : OWN1) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            last_q  <= OWNER_M1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_q | (s_readdatavalid & fifo_empty);
        end
    end

    sdram_arb_pend_fifo #(
        .DEPTH    (MAX_PEND)
    ) u_pend (
        .clk_i    (clk_clk),
        .rst_i    (reset_reset),
        .push_i   (accept & s_read),
        .push_id_i(own),
        .pop_i    (s_readdatavalid),
        .head_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == OWNER_M0);
    assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == OWNER_M1);
    assign err_orphan       = err_q;

`ifdef SDRAM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept && own == OWNER_M0 && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
            if (accept && own == OWNER_M1 && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: reset, single write, alternating reads, FIFO-full stall, orphan flag.
// Grant counters are exercised when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_rr_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_reset;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic          err_orphan;
`ifdef SDRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    sdram_rr_arbiter dut (
        .clk_clk         (clk),
        .reset_reset     (reset_reset),
        .m0_address      (m0_address),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_writedata    (m0_writedata),
        .m0_byteenable   (m0_byteenable),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address      (m1_address),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_writedata    (m1_writedata),
        .m1_byteenable   (m1_byteenable),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
`ifdef SDRAM_ARB_STATS_EN
        .stats_clr       (stats_clr),
        .grant_cnt0      (grant_cnt0),
        .grant_cnt1      (grant_cnt1),
`endif
        .err_orphan      (err_orphan)
    );

    int errs = 0;
    int checks = 0;

    int          acc_id[$];
    logic [15:0] acc_addr[$];
    int          ret_id[$];
    logic [15:0] ret_dat[$];

    int          exp_id[4]  = '{0, 1, 0, 1};
    logic [15:0] exp_dat[4] = '{16'h00A0, 16'h00B0, 16'h00A1, 16'h00B1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = 2'b11;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = 2'b11;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    // Returns one time unit after a rising edge with reset already released.
    task automatic do_reset();
        reset_reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_reset = 1'b0;
    endtask

    // Masters issue n0/n1 back-to-back commands; the slave model returns read data 3 cycles after accept.
    task automatic run_traffic(input int n0, input int n1, input bit rd, input int ncyc);
        int          i0 = 0;
        int          i1 = 0;
        bit          rv[64];
        logic [15:0] rdat[64];
        for (int k = 0; k < 64; k++) begin
            rv[k] = 1'b0;
            rdat[k] = '0;
        end
        acc_id.delete(); acc_addr.delete(); ret_id.delete(); ret_dat.delete();
        for (int c = 0; c < ncyc; c++) begin
            m0_read = rd && (i0 < n0);
            m0_write = !rd && (i0 < n0);
            m0_address = AW'(32'h0A0 + i0);
            m0_writedata = DW'(32'h0A0 + i0);
            m1_read = rd && (i1 < n1);
            m1_write = !rd && (i1 < n1);
            m1_address = AW'(32'h0B0 + i1);
            m1_writedata = DW'(32'h0B0 + i1);
            s_readdatavalid = rv[c];
            s_readdata = rdat[c];
            #1;
            if ((m0_read || m0_write) && !m0_waitrequest) begin
                acc_id.push_back(0);
                acc_addr.push_back(s_address[15:0]);
                if (rd && c + 3 < 64) begin
                    rv[c+3] = 1'b1;
                    rdat[c+3] = s_address[15:0];
                end
                i0++;
            end
            if ((m1_read || m1_write) && !m1_waitrequest) begin
                acc_id.push_back(1);
                acc_addr.push_back(s_address[15:0]);
                if (rd && c + 3 < 64) begin
                    rv[c+3] = 1'b1;
                    rdat[c+3] = s_address[15:0];
                end
                i1++;
            end
            if (m0_readdatavalid) begin
                ret_id.push_back(0);
                ret_dat.push_back(m0_readdata);
            end
            if (m1_readdatavalid) begin
                ret_id.push_back(1);
                ret_dat.push_back(m1_readdata);
            end
            @(posedge clk);
            #1;
        end
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        int  nacc;
        bit  exp_rd;

        // Reset state after idle cycles
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_err", err_orphan, 0);

        // Single m0 write: grant one cycle after the request
        m0_address = AW'(32'h123);
        m0_writedata = 16'h5A5A;
        m0_write = 1'b1;
        #1;
        chk("wr_lat_wait", m0_waitrequest, 1);
        chk("wr_lat_swrite", s_write, 0);
        @(posedge clk);
        #2;
        chk("wr_s_write", s_write, 1);
        chk("wr_addr", s_address, 32'h123);
        chk("wr_wdata", s_writedata, 32'h5A5A);
        chk("wr_m0_wait", m0_waitrequest, 0);
        chk("wr_m1_wait", m1_waitrequest, 1);
        chk("wr_rdv0", m0_readdatavalid, 0);
        chk("wr_rdv1", m1_readdatavalid, 0);
        @(posedge clk);
        #1;
        m0_write = 1'b0;
        #1;
        chk("wr_done", s_write, 0);

        // Both masters reading: accepts alternate and returns steer by issue order
        do_reset();
        run_traffic(2, 2, 1'b1, 12);
        chk("rd_nacc", acc_id.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_acc_id%0d", k), (k < acc_id.size()) ? acc_id[k] : -1, exp_id[k]);
            chk($sformatf("rd_acc_addr%0d", k), (k < acc_addr.size()) ? {16'h0, acc_addr[k]} : 32'hFFFF_FFFF, {16'h0, exp_dat[k]});
        end
        chk("rd_nret", ret_id.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_ret_id%0d", k), (k < ret_id.size()) ? ret_id[k] : -1, exp_id[k]);
            chk($sformatf("rd_ret_dat%0d", k), (k < ret_dat.size()) ? {16'h0, ret_dat[k]} : 32'hFFFF_FFFF, {16'h0, exp_dat[k]});
        end

        // Five m1 reads with no returns: fifth stalls until a return frees a slot
        do_reset();
        nacc = 0;
        m1_read = 1'b1;
        for (int c = 0; c < 9; c++) begin
            m1_address = AW'(32'h0C0 + nacc);
            s_readdatavalid = (c == 7);
            s_readdata = 16'h0055;
            #1;
            exp_rd = ((c >= 1) && (c <= 4)) || (c == 8);
            chk($sformatf("full_s_read_c%0d", c), s_read, exp_rd);
            chk($sformatf("full_m1_wait_c%0d", c), m1_waitrequest, !exp_rd);
            if (c == 7) begin
                chk("full_rdv1", m1_readdatavalid, 1);
                chk("full_rdv0", m0_readdatavalid, 0);
            end
            if (s_read && !s_waitrequest) nacc++;
            @(posedge clk);
            #1;
        end
        m1_read = 1'b0;
        s_readdatavalid = 1'b0;
        chk("full_nacc", nacc, 5);

        // Orphan readdatavalid sets a sticky error cleared only by reset
        do_reset();
        #1;
        chk("orph_init", err_orphan, 0);
        s_readdatavalid = 1'b1;
        #1;
        chk("orph_rdv0", m0_readdatavalid, 0);
        chk("orph_rdv1", m1_readdatavalid, 0);
        @(posedge clk);
        #1;
        s_readdatavalid = 1'b0;
        #1;
        chk("orph_set", err_orphan, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("orph_sticky", err_orphan, 1);
        do_reset();
        #1;
        chk("orph_clr", err_orphan, 0);

`ifdef SDRAM_ARB_STATS_EN
        // Grant counters: 3 m0 and 2 m1 write accepts, then clear
        do_reset();
        #1;
        chk("st_rst0", grant_cnt0, 0);
        chk("st_rst1", grant_cnt1, 0);
        @(posedge clk);
        #1;
        run_traffic(3, 2, 1'b0, 8);
        chk("st_cnt0", grant_cnt0, 3);
        chk("st_cnt1", grant_cnt1, 2);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        #1;
        chk("st_clr0", grant_cnt0, 0);
        chk("st_clr1", grant_cnt1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sdram_rr_arbiter.md
Name: sdram_rr_arbiter

Overview:
- Two-master round-robin arbiter sharing the single Avalon-MM slave port of the on-board SDRAM controller (16-bit data, 13-bit row, 2-bit bank).
- Sits between the Nios II data master (m0) and a DMA/custom-instruction memory master (m1) on one side, and the SDRAM controller slave (s_) on the other.
- Tracks outstanding pipelined reads so each readdatavalid is returned to the master that issued the read.

Parameters:
- ADDR_W, 25, halfword address width (13 row + 10 col + 2 bank).
- DATA_W, 16, data width.
- MAX_PEND, 4, maximum outstanding reads; power of 2, >= 2.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- mN_address  in  ADDR_W  master N (N = 0, 1) address.
- mN_read, mN_write  in  1 each  master N commands.
- mN_writedata  in  DATA_W  master N write data.
- mN_byteenable  in  2  master N byte enables.
- mN_waitrequest  out  1  master N stall.
- mN_readdata  out  DATA_W  read data, shared by both masters.
- mN_readdatavalid  out  1  read data valid, master N.
- s_address  out  ADDR_W  address to SDRAM controller.
- s_read, s_write  out  1 each  commands to SDRAM controller.
- s_writedata  out  DATA_W  write data to SDRAM controller.
- s_byteenable  out  2  byte enables to SDRAM controller.
- s_waitrequest  in  1  SDRAM controller stall.
- s_readdata  in  DATA_W  read data from SDRAM controller.
- s_readdatavalid  in  1  read data valid from SDRAM controller.
- err_orphan  out  1  sticky: readdatavalid arrived with no read pending.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, round-robin pointer last = 1 (so m0 wins the first tie), pending FIFO empty, err_orphan = 0.
  - Outputs: s_read = s_write = 0; mN_waitrequest = 1; mN_readdatavalid = 0.
- Request: reqN = mN_read | mN_write. Masters hold their command stable while waitrequest is high; withdrawal is illegal and not checked.
- FSM states IDLE, OWN0, OWN1:
  - IDLE: if only one master requests, go to its OWN state; if both, go to the OWN state of the master != last. Grant costs one cycle from IDLE.
  - OWNx: s_* driven combinationally from mx; mx_waitrequest = s_waitrequest | blk; the other master's waitrequest = 1.
  - blk = mx_read & fifo_full. While blk, s_read is forced to 0.
  - accept = (s_read | s_write) & ~s_waitrequest. On accept, last <= x.
  - Next state after accept: OWN(other) if req(other), else stay in OWNx (parking).
  - OWNx with ~reqx: go to OWN(other) if req(other), else IDLE.
- Pending FIFO (owner IDs, depth MAX_PEND):
  - Push x on a read accept.
  - Pop on s_readdatavalid. The head ID selects which mN_readdatavalid is asserted in the same cycle (zero added latency). mN_readdata = s_readdata for both masters.
  - Writes are never tracked.
  - Push and pop in the same cycle: allowed when not full; count unchanged.
  - When full: push is blocked even if a pop occurs that cycle, so fifo_full is a registered-only path.
  - Pointers wrap modulo MAX_PEND.
- s_readdatavalid with the FIFO empty: no mN_readdatavalid is asserted and err_orphan is set. err_orphan is cleared only by reset.
- Reset mid-operation: the FIFO is flushed and the grant is dropped. The SDRAM controller shares the same reset.

Optional Feature:
- Macro SDRAM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - grant_cntN increments on each accept by master N and saturates at all-ones.
  - stats_clr or reset zeroes both counters; stats_clr has priority over an increment in the same cycle.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum typedef arb_state_t {IDLE, OWN0, OWN1};
  - owner_t (1 bit);
  - constants OWNER_M0 = 0 and OWNER_M1 = 1.
- Sub-module sdram_arb_pend_fifo: parameterised owner-ID FIFO with push, pop, head, full and empty outputs and synchronous reset.

Test Plan:
- Reset, then idle cycles -> s_read = s_write = 0, m0/m1_waitrequest = 1, err_orphan = 0.
- m0 single write to addr 0x0000123, s_waitrequest = 0:
  - grant is seen 1 cycle after the request;
  - s_address = 0x0000123 in the accept cycle;
  - no readdatavalid on either master.
- m0 and m1 both issue continuous reads, with the slave returning data 3 cycles after accept:
  - accepts alternate m0, m1, m0, m1;
  - each mN_readdatavalid matches its issue order;
  - the m0/m1 return sequence is 0xA0, 0xB0, 0xA1, 0xB1.
- m1 issues 5 reads with no readdatavalid returned (MAX_PEND = 4):
  - the 5th read is held (m1_waitrequest = 1, s_read = 0);
  - it is released the cycle after the first readdatavalid.
- s_readdatavalid pulsed with nothing pending -> err_orphan = 1 and stays 1; it clears only after reset_reset.
- With SDRAM_ARB_STATS_EN: 3 m0 accepts and 2 m1 accepts -> grant_cnt0 = 3, grant_cnt1 = 2; stats_clr -> both 0 on the next cycle.
